// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage_pkg: shared definitions for the ID/EX operand stage.
// Holds the ALU op encoding, operand-select enums, forwarding-source enum,
// the held instruction payload and the RAW source-match helper.
package ex_operand_stage_pkg;

    localparam int Width = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic {
        B_SEL_RS2 = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Everything captured from ID for one instruction.
    typedef struct packed {
        alu_op_e          op;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [Width-1:0] rs1_data;
        logic [Width-1:0] rs2_data;
        logic [Width-1:0] pc;
        logic [Width-1:0] imm;
        a_sel_e           a_sel;
        b_sel_e           b_sel;
        logic             we;
        logic             load;
    } id_payload_t;

    // A producer matches a source when it writes the same non-x0 register.
    function automatic logic src_match(input logic src_we, input logic [4:0] src_rd,
                                       input logic [4:0] rs);
        return src_we && (src_rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_unit.sv
// fwd_unit: RAW resolution for one source operand.
// Build option: EX_OPERAND_FORWARD_EN selects MEM/WB forwarding with a
// load-use interlock; without it every MEM or WB match on a used source stalls.
module fwd_unit
    import ex_operand_stage_pkg::*;
(
    input  logic [4:0]       rs_i,
    input  logic             used_i,
    input  logic [Width-1:0] rf_data_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_we_i,
    input  logic             mem_load_i,
    input  logic [Width-1:0] mem_result_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             wb_we_i,
    input  logic [Width-1:0] wb_result_i,
    output fwd_sel_e         sel_o,
    output logic [Width-1:0] data_o,
    output logic             stall_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = used_i && src_match(mem_we_i, mem_rd_i, rs_i);
    assign wb_hit  = used_i && src_match(wb_we_i, wb_rd_i, rs_i);

`ifndef EX_OPERAND_FORWARD_EN
    // Load status is irrelevant when every match interlocks.
    logic unused_mem_load;
    assign unused_mem_load = mem_load_i;
`endif

    // Pick the operand source and decide whether the consumer must wait.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        sel_o   = FWD_RF;
        stall_o = 1'b0;
`ifdef EX_OPERAND_FORWARD_EN
        // Youngest producer wins; a load in MEM has no data yet.
        if (mem_hit) begin
            sel_o   = FWD_MEM;
            stall_o = mem_load_i;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
`else
        // RF data was sampled at ID, so even a WB producer is too late.
        stall_o = mem_hit || wb_hit;
`endif
        case (sel_o)
            FWD_MEM: data_o = mem_result_i;
            FWD_WB:  data_o = wb_result_i;
            default: data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX holding register with operand resolution.
// Build option: define EX_OPERAND_FORWARD_EN for MEM/WB forwarding (only
// load-use interlocks); undefined, any RAW match on a used source interlocks.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  alu_op_e          id_op_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic [Width-1:0] id_rs1_data_i,
    input  logic [Width-1:0] id_rs2_data_i,
    input  logic [Width-1:0] id_pc_i,
    input  logic [Width-1:0] id_imm_i,
    input  a_sel_e           id_a_sel_i,
    input  b_sel_e           id_b_sel_i,
    input  logic             id_we_i,
    input  logic             id_load_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_we_i,
    input  logic             mem_load_i,
    input  logic [Width-1:0] mem_result_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             wb_we_i,
    input  logic [Width-1:0] wb_result_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output alu_op_e          ex_op_o,
    output logic [Width-1:0] ex_a_o,
    output logic [Width-1:0] ex_b_o,
    output logic [Width-1:0] ex_store_data_o,
    output logic [4:0]       ex_rd_o,
    output logic             ex_we_o,
    output logic             ex_load_o,
    output logic             stall_o
);

    logic             valid_q, valid_d;
    id_payload_t      id_q, id_d;
    logic             accept;
    logic             rs1_used, rs2_used;
    fwd_sel_e         rs1_sel, rs2_sel;
    logic [Width-1:0] rs1_fwd, rs2_fwd;
    logic             rs1_stall, rs2_stall;
    logic             unused_fwd_sel;

    assign stall_o    = valid_q && (rs1_stall || rs2_stall);
    assign id_ready_o = !valid_q || (ex_ready_i && !stall_o);
    assign ex_valid_o = valid_q && !stall_o;
    assign accept     = id_valid_i && id_ready_o;

    // rs2 also feeds store data, so it is always a live source.
    assign rs1_used = (id_q.a_sel == A_SEL_RS1);
    assign rs2_used = 1'b1;

    // The ALU only needs the resolved data; the selects stay internal.
    assign unused_fwd_sel = ^{rs1_sel, rs2_sel};

    fwd_unit u_fwd_rs1 (
        .rs_i         (id_q.rs1),
        .used_i       (rs1_used),
        .rf_data_i    (id_q.rs1_data),
        .mem_rd_i     (mem_rd_i),
        .mem_we_i     (mem_we_i),
        .mem_load_i   (mem_load_i),
        .mem_result_i (mem_result_i),
        .wb_rd_i      (wb_rd_i),
        .wb_we_i      (wb_we_i),
        .wb_result_i  (wb_result_i),
        .sel_o        (rs1_sel),
        .data_o       (rs1_fwd),
        .stall_o      (rs1_stall)
    );

    fwd_unit u_fwd_rs2 (
        .rs_i         (id_q.rs2),
        .used_i       (rs2_used),
        .rf_data_i    (id_q.rs2_data),
        .mem_rd_i     (mem_rd_i),
        .mem_we_i     (mem_we_i),
        .mem_load_i   (mem_load_i),
        .mem_result_i (mem_result_i),
        .wb_rd_i      (wb_rd_i),
        .wb_we_i      (wb_we_i),
        .wb_result_i  (wb_result_i),
        .sel_o        (rs2_sel),
        .data_o       (rs2_fwd),
        .stall_o      (rs2_stall)
    );

    // Holding-register next state: flush beats accept, accept beats drain.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            id_d    = '{op:       id_op_i,
                        rs1:      id_rs1_i,
                        rs2:      id_rs2_i,
                        rd:       id_rd_i,
                        rs1_data: id_rs1_data_i,
                        rs2_data: id_rs2_data_i,
                        pc:       id_pc_i,
                        imm:      id_imm_i,
                        a_sel:    id_a_sel_i,
                        b_sel:    id_b_sel_i,
                        we:       id_we_i,
                        load:     id_load_i};
        end else if (ex_valid_o && ex_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Holding register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values whatever the statement order.
        if (rst_i) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset too, so the outputs read ADD/0 out of reset instead of X.
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    // Operand muxes feeding the ALU.
    always_comb begin
        case (id_q.a_sel)
            A_SEL_RS1: ex_a_o = rs1_fwd;
            A_SEL_PC:  ex_a_o = id_q.pc;
            default:   ex_a_o = '0;
        endcase
        ex_b_o = (id_q.b_sel == B_SEL_IMM) ? id_q.imm : rs2_fwd;
    end

    assign ex_store_data_o = rs2_fwd;
    assign ex_op_o         = id_q.op;
    assign ex_rd_o         = id_q.rd;
    assign ex_we_o         = id_q.we;
    assign ex_load_o       = id_q.load;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed stimulus with a scoreboard queue; a monitor
// pops and compares on every EX transfer. Expectations follow the build
// option EX_OPERAND_FORWARD_EN.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        we;
        logic        load;
    } exp_t;

    logic        clk;
    logic        rst_i, flush_i, id_valid_i, id_ready_o;
    alu_op_e     id_op_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_pc_i, id_imm_i;
    a_sel_e      id_a_sel_i;
    b_sel_e      id_b_sel_i;
    logic        id_we_i, id_load_i;
    logic [4:0]  mem_rd_i, wb_rd_i;
    logic        mem_we_i, mem_load_i, wb_we_i;
    logic [31:0] mem_result_i, wb_result_i;
    logic        ex_valid_o, ex_ready_i;
    alu_op_e     ex_op_o;
    logic [31:0] ex_a_o, ex_b_o, ex_store_data_o;
    logic [4:0]  ex_rd_o;
    logic        ex_we_o, ex_load_o, stall_o;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    ex_operand_stage dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_op_i(id_op_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_pc_i(id_pc_i), .id_imm_i(id_imm_i),
        .id_a_sel_i(id_a_sel_i), .id_b_sel_i(id_b_sel_i),
        .id_we_i(id_we_i), .id_load_i(id_load_i),
        .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i), .mem_load_i(mem_load_i),
        .mem_result_i(mem_result_i),
        .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i), .wb_result_i(wb_result_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_op_o(ex_op_o),
        .ex_a_o(ex_a_o), .ex_b_o(ex_b_o), .ex_store_data_o(ex_store_data_o),
        .ex_rd_o(ex_rd_o), .ex_we_o(ex_we_o), .ex_load_o(ex_load_o),
        .stall_o(stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Mid-cycle sample point and advance to just after the next edge.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_e op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] rs1d, input logic [31:0] rs2d,
                         input logic [31:0] pc, input logic [31:0] imm, input a_sel_e asel,
                         input b_sel_e bsel, input logic we, input logic ld);
        id_valid_i    = 1'b1;
        id_op_i       = op;
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_rd_i       = rd;
        id_rs1_data_i = rs1d;
        id_rs2_data_i = rs2d;
        id_pc_i       = pc;
        id_imm_i      = imm;
        id_a_sel_i    = asel;
        id_b_sel_i    = bsel;
        id_we_i       = we;
        id_load_i     = ld;
    endtask

    task automatic push(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sd, input logic [4:0] rd, input logic we,
                        input logic ld);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.sd = sd; e.rd = rd; e.we = we; e.load = ld;
        sb.push_back(e);
    endtask

    task automatic clear_producers();
        mem_rd_i = 5'd0; mem_we_i = 1'b0; mem_load_i = 1'b0; mem_result_i = 32'h0;
        wb_rd_i  = 5'd0; wb_we_i  = 1'b0; wb_result_i = 32'h0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ex_valid"}, ex_valid_o, 0);
        check({tag, "_id_ready"}, id_ready_o, 1);
        check({tag, "_stall"}, stall_o, 0);
        check({tag, "_op"}, ex_op_o, ALU_ADD);
        check({tag, "_a"}, ex_a_o, 0);
        check({tag, "_b"}, ex_b_o, 0);
        check({tag, "_store"}, ex_store_data_o, 0);
        check({tag, "_rd"}, ex_rd_o, 0);
        check({tag, "_we"}, ex_we_o, 0);
        check({tag, "_load"}, ex_load_o, 0);
    endtask

    // Monitor: every EX transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst_i && ex_valid_o && ex_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got a=0x%08h with empty scoreboard (t=%0t)",
                         ex_a_o, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_op", ex_op_o, e.op);
                check("sb_a", ex_a_o, e.a);
                check("sb_b", ex_b_o, e.b);
                check("sb_store", ex_store_data_o, e.sd);
                check("sb_rd", ex_rd_o, e.rd);
                check("sb_we", ex_we_o, e.we);
                check("sb_load", ex_load_o, e.load);
            end
        end
    end

    // Run-time bound.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b1;
        drive(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, A_SEL_RS1, B_SEL_RS2, 0, 0);
        id_valid_i = 1'b0;
        clear_producers();
        repeat (3) nxt();
        mid();
        check_reset_state("reset");
        nxt();
        rst_i = 1'b0;

        // Basic ADD: rs1 data 5, immediate 7, one-cycle latency.
        drive(ALU_ADD, 1, 0, 2, 32'd5, 0, 0, 32'd7, A_SEL_RS1, B_SEL_IMM, 1, 0);
        push(ALU_ADD, 32'd5, 32'd7, 0, 2, 1, 0);
        mid(); check("add_id_ready", id_ready_o, 1);
        nxt(); id_valid_i = 1'b0;
        mid(); check("add_latency_valid", ex_valid_o, 1);
        nxt();
        mid(); check("add_drained", ex_valid_o, 0);
        nxt();

        // Back-to-back throughput across all operand selects.
        drive(ALU_SUB, 5, 6, 7, 32'h10, 32'h3, 32'h100, 32'h4, A_SEL_PC, B_SEL_IMM, 1, 0);
        push(ALU_SUB, 32'h100, 32'h4, 32'h3, 7, 1, 0);
        nxt();
        drive(ALU_XOR, 8, 9, 10, 32'h77, 32'h55, 0, 0, A_SEL_ZERO, B_SEL_RS2, 1, 0);
        push(ALU_XOR, 32'h0, 32'h55, 32'h55, 10, 1, 0);
        mid(); check("tput_ready1", id_ready_o, 1);
        nxt();
        drive(ALU_OR, 11, 12, 13, 32'hF0, 32'h0F, 0, 0, A_SEL_RS1, B_SEL_RS2, 0, 1);
        push(ALU_OR, 32'hF0, 32'h0F, 32'h0F, 13, 0, 1);
        mid(); check("tput_ready2", id_ready_o, 1);
        nxt(); id_valid_i = 1'b0;
        mid(); nxt();

        // MEM and WB both write x3: MEM has priority.
        drive(ALU_AND, 3, 0, 14, 32'h11, 0, 0, 32'h1, A_SEL_RS1, B_SEL_IMM, 1, 0);
`ifdef EX_OPERAND_FORWARD_EN
        push(ALU_AND, 32'hAA, 32'h1, 0, 14, 1, 0);
`else
        push(ALU_AND, 32'h11, 32'h1, 0, 14, 1, 0);
`endif
        nxt(); id_valid_i = 1'b0;
        mem_rd_i = 5'd3; mem_we_i = 1'b1; mem_result_i = 32'hAA;
        wb_rd_i  = 5'd3; wb_we_i  = 1'b1; wb_result_i  = 32'hBB;
`ifdef EX_OPERAND_FORWARD_EN
        mid(); check("prio_no_stall", stall_o, 0);
        nxt(); clear_producers();
`else
        mid();
        check("prio_stall", stall_o, 1);
        check("prio_bubble", ex_valid_o, 0);
        check("prio_id_ready", id_ready_o, 0);
        nxt();
        mid(); check("prio_stall_persists", stall_o, 1);
        nxt(); clear_producers();
        mid(); check("prio_stall_clear", stall_o, 0);
        nxt();
`endif

        // Load-use on rs2 = x4.
        drive(ALU_SLT, 0, 4, 15, 0, 32'h9, 0, 0, A_SEL_RS1, B_SEL_RS2, 1, 0);
`ifdef EX_OPERAND_FORWARD_EN
        push(ALU_SLT, 32'h0, 32'h1234, 32'h1234, 15, 1, 0);
`else
        push(ALU_SLT, 32'h0, 32'h9, 32'h9, 15, 1, 0);
`endif
        nxt(); id_valid_i = 1'b0;
        mem_rd_i = 5'd4; mem_we_i = 1'b1; mem_load_i = 1'b1; mem_result_i = 32'hDEAD;
        mid();
        check("lu_stall", stall_o, 1);
        check("lu_bubble", ex_valid_o, 0);
        check("lu_id_ready", id_ready_o, 0);
        nxt();
        mem_we_i = 1'b0; mem_load_i = 1'b0;
        wb_rd_i = 5'd4; wb_we_i = 1'b1; wb_result_i = 32'h1234;
`ifdef EX_OPERAND_FORWARD_EN
        mid(); check("lu_one_bubble", stall_o, 0);
        nxt(); clear_producers();
`else
        mid(); check("lu_wb_stall", stall_o, 1);
        nxt(); clear_producers();
        mid(); check("lu_clear", stall_o, 0);
        nxt();
`endif

        // x0 never matches, even against a load writing x0.
        drive(ALU_OR, 0, 0, 1, 0, 0, 0, 32'h3, A_SEL_RS1, B_SEL_IMM, 1, 0);
        push(ALU_OR, 32'h0, 32'h3, 32'h0, 1, 1, 0);
        nxt(); id_valid_i = 1'b0;
        mem_rd_i = 5'd0; mem_we_i = 1'b1; mem_load_i = 1'b1; mem_result_i = 32'hFF;
        wb_rd_i  = 5'd0; wb_we_i  = 1'b1; wb_result_i  = 32'hEE;
        mid();
        check("x0_no_stall", stall_o, 0);
        check("x0_a_zero", ex_a_o, 0);
        nxt(); clear_producers();

        // Backpressure for 3 cycles, then drain and accept on the same edge.
        ex_ready_i = 1'b0;
        drive(ALU_SRA, 2, 3, 4, 32'h80, 32'h2, 0, 0, A_SEL_RS1, B_SEL_RS2, 1, 0);
        push(ALU_SRA, 32'h80, 32'h2, 32'h2, 4, 1, 0);
        nxt();
        drive(ALU_SLL, 5, 6, 7, 32'h1, 32'h4, 0, 32'h8, A_SEL_RS1, B_SEL_IMM, 1, 0);
        push(ALU_SLL, 32'h1, 32'h8, 32'h4, 7, 1, 0);
        for (int i = 0; i < 3; i++) begin
            mid();
            check("bp_id_ready", id_ready_o, 0);
            check("bp_valid", ex_valid_o, 1);
            check("bp_a_stable", ex_a_o, 32'h80);
            check("bp_b_stable", ex_b_o, 32'h2);
            nxt();
        end
        ex_ready_i = 1'b1;
        mid(); check("bp_release_ready", id_ready_o, 1);
        nxt(); id_valid_i = 1'b0;
        mid(); check("bp_reload_valid", ex_valid_o, 1);
        nxt();

        // Flush with a simultaneous accept: nothing is captured.
        flush_i = 1'b1;
        drive(ALU_XOR, 1, 2, 3, 32'h5, 32'h6, 0, 0, A_SEL_RS1, B_SEL_RS2, 1, 0);
        nxt(); flush_i = 1'b0; id_valid_i = 1'b0;
        mid(); check("flush_accept_valid", ex_valid_o, 0);
        nxt();

        // Flush of a held instruction.
        ex_ready_i = 1'b0;
        drive(ALU_AND, 1, 2, 3, 32'h5, 32'h6, 0, 0, A_SEL_RS1, B_SEL_RS2, 1, 0);
        nxt(); id_valid_i = 1'b0; flush_i = 1'b1;
        mid(); check("flush_held_before", ex_valid_o, 1);
        nxt(); flush_i = 1'b0;
        mid();
        check("flush_held_after", ex_valid_o, 0);
        check("flush_held_ready", id_ready_o, 1);
        ex_ready_i = 1'b1;
        nxt();

        // Reset asserted during a load-use stall.
        drive(ALU_SUB, 6, 0, 9, 32'h42, 0, 0, 32'h5, A_SEL_RS1, B_SEL_IMM, 1, 1);
        nxt(); id_valid_i = 1'b0;
        mem_rd_i = 5'd6; mem_we_i = 1'b1; mem_load_i = 1'b1; mem_result_i = 32'h77;
        mid(); check("rst_pre_stall", stall_o, 1);
        nxt();
        rst_i = 1'b1;
        drive(ALU_XOR, 7, 8, 9, 32'h1, 32'h2, 0, 0, A_SEL_RS1, B_SEL_RS2, 1, 0);
        nxt();
        rst_i = 1'b0; id_valid_i = 1'b0;
        mid();
        check_reset_state("rst_mid_stall");
        nxt(); clear_producers();

        mid();
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
